// File: rtl/axilite_uart_tx_arbiter_pkg.sv
// Shared constants and types for the AXI-Lite UART transmit arbiter:
// UART register map, STAT bit positions and the arbiter FSM state type.
package axilite_uart_tx_arbiter_pkg;

    // UART register offsets relative to the UART base address
    localparam int UART_RX_OFF   = 'h0;
    localparam int UART_TX_OFF   = 'h4;
    localparam int UART_STAT_OFF = 'h8;
    localparam int UART_CTRL_OFF = 'hC;

    // STAT register bit indices
    localparam int UART_STAT_RX_VALID_BIT = 0;
    localparam int UART_STAT_RX_FULL_BIT  = 1;
    localparam int UART_STAT_TX_EMPTY_BIT = 2;
    localparam int UART_STAT_TX_FULL_BIT  = 3;

    // CTRL value that resets both the TX and RX FIFOs
    localparam logic [31:0] UART_CTRL_FIFO_RST = 32'h0000_0003;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // INIT/INIT_WR/INIT_B run once after reset; the rest is the per-byte loop
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_INIT_WR = 3'd1,
        ST_INIT_B  = 3'd2,
        ST_IDLE    = 3'd3,
        ST_RD_STAT = 3'd4,
        ST_WAIT_R  = 3'd5,
        ST_WR      = 3'd6,
        ST_WAIT_B  = 3'd7
    } uart_tx_arb_state_t;

    // States that drive the AW and W channels
    function automatic logic is_write_state(uart_tx_arb_state_t s);
        return (s == ST_INIT_WR) || (s == ST_WR);
    endfunction

endpackage

// File: rtl/axilite_uart_tx_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// wrapping modulo N. The pointer moves to grant+1 when the grant is used.
module axilite_uart_tx_arbiter_rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic          any,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW:0]   cand;

    // Scan from the pointer and take the first active request
    always_comb begin
        any       = 1'b0;
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!any && req[cand[IW-1:0]]) begin
                any       = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
        grant[grant_idx] = any;
    end

    // Pointer moves past the requester that was just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/axilite_uart_tx_arbiter.sv
// AXI4-Lite master sharing the UART TX FIFO between NUM_REQ byte streams.
// After reset it writes CTRL to flush the UART FIFOs, then per granted byte
// polls STAT until TX is not full and writes the byte to the TX register.
//
// Handshakes: a transfer happens on the rising edge where valid and ready
// are both high. Once raised, a valid and its payload stay stable until that
// edge; ready may be driven freely. Requesters hold req_valid_i/req_data_i
// until req_ready_o (a one-cycle grant pulse, only in IDLE).
module axilite_uart_tx_arbiter
    import axilite_uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LOCAL_ADDR_WIDTH = 32,
    parameter int LOCAL_DATA_WIDTH = 32,
    parameter logic [LOCAL_ADDR_WIDTH-1:0] UART_BASE_ADDR = '0,
    parameter int MAX_POLL = 1024
) (
    input  logic                              clock_i,
    input  logic                              reset_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][7:0]           req_data_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic                              busy_o,
    output logic                              err_o,
    input  logic                              err_clr_i,
    output uart_tx_arb_state_t                dbg_state_o,
    output logic [LOCAL_ADDR_WIDTH-1:0]       m_axilite_awaddr,
    output logic [2:0]                        m_axilite_awprot,
    output logic                              m_axilite_awvalid,
    input  logic                              m_axilite_awready,
    output logic [LOCAL_DATA_WIDTH-1:0]       m_axilite_wdata,
    output logic [LOCAL_DATA_WIDTH/8-1:0]     m_axilite_wstrb,
    output logic                              m_axilite_wvalid,
    input  logic                              m_axilite_wready,
    input  logic [1:0]                        m_axilite_bresp,
    input  logic                              m_axilite_bvalid,
    output logic                              m_axilite_bready,
    output logic [LOCAL_ADDR_WIDTH-1:0]       m_axilite_araddr,
    output logic [2:0]                        m_axilite_arprot,
    output logic                              m_axilite_arvalid,
    input  logic                              m_axilite_arready,
    input  logic [LOCAL_DATA_WIDTH-1:0]       m_axilite_rdata,
    input  logic [1:0]                        m_axilite_rresp,
    input  logic                              m_axilite_rvalid,
    output logic                              m_axilite_rready
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (MAX_POLL > 1) ? $clog2(MAX_POLL) : 1;

    localparam logic [LOCAL_ADDR_WIDTH-1:0] TX_ADDR   = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(UART_TX_OFF);
    localparam logic [LOCAL_ADDR_WIDTH-1:0] STAT_ADDR = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(UART_STAT_OFF);
    localparam logic [LOCAL_ADDR_WIDTH-1:0] CTRL_ADDR = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(UART_CTRL_OFF);

    uart_tx_arb_state_t state_q, state_d;

    logic                 any_valid;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [IW-1:0]        grant_idx;
    logic                 grant_en;

    logic [7:0]           byte_q;
    logic [PW-1:0]        poll_q;
    logic                 busy_q;
    logic                 err_q;
    logic                 awvalid_q, wvalid_q, arvalid_q;

    logic aw_hs, w_hs, ar_hs, r_hs, b_hs;
    logic wr_done, stat_ok, tx_full, poll_last, err_set;
    logic enter_wr, enter_rd;
    logic unused_rdata;

    axilite_uart_tx_arbiter_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk       (clock_i),
        .rst_n     (reset_ni),
        .req       (req_valid_i),
        .advance   (grant_en),
        .any       (any_valid),
        .grant     (grant_oh),
        .grant_idx (grant_idx)
    );

    assign aw_hs     = awvalid_q & m_axilite_awready;
    assign w_hs      = wvalid_q  & m_axilite_wready;
    assign ar_hs     = arvalid_q & m_axilite_arready;
    assign r_hs      = m_axilite_rvalid & m_axilite_rready;
    assign b_hs      = m_axilite_bvalid & m_axilite_bready;
    // AW and W finish independently; the write is done once neither is pending
    assign wr_done   = (!awvalid_q || aw_hs) && (!wvalid_q || w_hs);
    assign stat_ok   = (m_axilite_rresp == AXI_RESP_OKAY);
    assign tx_full   = m_axilite_rdata[UART_STAT_TX_FULL_BIT];
    assign poll_last = (poll_q == PW'(MAX_POLL-1));
    assign err_set   = (r_hs && (!stat_ok || (tx_full && poll_last)))
                     || (b_hs && (m_axilite_bresp != AXI_RESP_OKAY));
    assign enter_wr  = is_write_state(state_d) && (state_d != state_q);
    assign enter_rd  = (state_d == ST_RD_STAT) && (state_q != ST_RD_STAT);
    // Only the TX-full bit of STAT matters here
    assign unused_rdata = ^m_axilite_rdata;

    // State register
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_INIT_WR;
            ST_INIT_WR: if (wr_done) state_d = ST_INIT_B;
            ST_INIT_B:  if (b_hs) state_d = ST_IDLE;
            ST_IDLE:    if (any_valid) state_d = ST_RD_STAT;
            ST_RD_STAT: if (ar_hs) state_d = ST_WAIT_R;
            ST_WAIT_R: begin
                if (r_hs) begin
                    if (!stat_ok) begin
                        state_d = ST_IDLE;
                    end else if (tx_full) begin
                        state_d = poll_last ? ST_IDLE : ST_RD_STAT;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR:      if (wr_done) state_d = ST_WAIT_B;
            ST_WAIT_B:  if (b_hs) state_d = ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    // State-decoded outputs: response readies, grant pulse, write payload
    always_comb begin
        m_axilite_rready = (state_q == ST_WAIT_R);
        m_axilite_bready = (state_q == ST_INIT_B) || (state_q == ST_WAIT_B);
        grant_en         = (state_q == ST_IDLE) && any_valid;
        req_ready_o      = grant_en ? grant_oh : '0;
        m_axilite_awaddr = (state_q == ST_INIT_WR) ? CTRL_ADDR : TX_ADDR;
        m_axilite_wdata  = (state_q == ST_INIT_WR) ? LOCAL_DATA_WIDTH'(UART_CTRL_FIFO_RST)
                                                   : LOCAL_DATA_WIDTH'(byte_q);
    end

    // AW/W valids: both raised on write entry, each dropped on its own handshake
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else if (enter_wr) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
        end else begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
        end
    end

    // AR valid: raised on each STAT poll, dropped on its handshake
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            arvalid_q <= 1'b0;
        end else if (enter_rd) begin
            arvalid_q <= 1'b1;
        end else if (ar_hs) begin
            arvalid_q <= 1'b0;
        end
    end

    // Granted byte, poll count (cleared on every return to IDLE) and busy flag
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            byte_q <= '0;
            poll_q <= '0;
            busy_q <= 1'b0;
        end else begin
            if (grant_en) begin
                byte_q <= req_data_i[grant_idx];
            end
            if (state_d == ST_IDLE) begin
                poll_q <= '0;
            end else if (r_hs && stat_ok && tx_full) begin
                poll_q <= poll_q + PW'(1);
            end
            busy_q <= (state_d != ST_IDLE);
        end
    end

    // Sticky error; a new error in the clear cycle is kept
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign m_axilite_awvalid = awvalid_q;
    assign m_axilite_wvalid  = wvalid_q;
    assign m_axilite_arvalid = arvalid_q;
    assign m_axilite_araddr  = STAT_ADDR;
    assign m_axilite_awprot  = 3'b000;
    assign m_axilite_arprot  = 3'b000;
    assign m_axilite_wstrb   = (LOCAL_DATA_WIDTH/8)'(1);
    assign busy_o            = busy_q;
    assign err_o             = err_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_axilite_uart_tx_arbiter.sv
// Directed bench for axilite_uart_tx_arbiter with a small AXI-Lite UART
// slave model whose STAT replies, write-channel delays and B response are
// steered from the stimulus sequence.
module tb_axilite_uart_tx_arbiter;
    import axilite_uart_tx_arbiter_pkg::*;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] TX_A   = BASE + 32'h4;
    localparam logic [31:0] STAT_A = BASE + 32'h8;
    localparam logic [31:0] CTRL_A = BASE + 32'hC;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]         req_valid;
    logic [1:0][7:0]    req_data;
    logic [1:0]         req_ready;
    logic               busy, err, err_clr;
    uart_tx_arb_state_t dbg_state;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;

    axilite_uart_tx_arbiter #(
        .NUM_REQ          (2),
        .LOCAL_ADDR_WIDTH (32),
        .LOCAL_DATA_WIDTH (32),
        .UART_BASE_ADDR   (BASE),
        .MAX_POLL         (4)
    ) dut (
        .clock_i           (clk),
        .reset_ni          (rst_n),
        .req_valid_i       (req_valid),
        .req_data_i        (req_data),
        .req_ready_o       (req_ready),
        .busy_o            (busy),
        .err_o             (err),
        .err_clr_i         (err_clr),
        .dbg_state_o       (dbg_state),
        .m_axilite_awaddr  (awaddr),
        .m_axilite_awprot  (awprot),
        .m_axilite_awvalid (awvalid),
        .m_axilite_awready (awready),
        .m_axilite_wdata   (wdata),
        .m_axilite_wstrb   (wstrb),
        .m_axilite_wvalid  (wvalid),
        .m_axilite_wready  (wready),
        .m_axilite_bresp   (bresp),
        .m_axilite_bvalid  (bvalid),
        .m_axilite_bready  (bready),
        .m_axilite_araddr  (araddr),
        .m_axilite_arprot  (arprot),
        .m_axilite_arvalid (arvalid),
        .m_axilite_arready (arready),
        .m_axilite_rdata   (rdata),
        .m_axilite_rresp   (rresp),
        .m_axilite_rvalid  (rvalid),
        .m_axilite_rready  (rready)
    );

    // ---------------- slave model ----------------
    int          cfg_aw_delay = 0;
    int          cfg_w_delay  = 0;
    logic [1:0]  cfg_bresp    = 2'b00;
    logic        cfg_r_hold   = 1'b0;
    int          full_until   = 0;     // reads with index below this report TX full

    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    logic [31:0] ar_log[$];
    int          ready_cnt0 = 0;
    int          ready_cnt1 = 0;

    logic got_aw, got_w, r_pend;
    int   aw_cnt, w_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
            got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0;
        end else begin
            arready <= 1'b1;
            if (awvalid && awready) begin
                aw_log.push_back(awaddr);
                awready <= 1'b0; got_aw <= 1'b1; aw_cnt <= 0;
            end else if (awvalid && !got_aw && !awready) begin
                if (aw_cnt >= cfg_aw_delay) awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                w_log.push_back(wdata);
                wready <= 1'b0; got_w <= 1'b1; w_cnt <= 0;
            end else if (wvalid && !got_w && !wready) begin
                if (w_cnt >= cfg_w_delay) wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end else if (got_aw && got_w && !bvalid) begin
                bvalid <= 1'b1; bresp <= cfg_bresp; got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (arvalid && arready) begin
                rdata <= (ar_log.size() < full_until) ? 32'h8 : 32'h0;
                rresp <= 2'b00;
                r_pend <= 1'b1;
                ar_log.push_back(araddr);
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; r_pend <= 1'b0;
            end else if (r_pend && !rvalid && !cfg_r_hold) begin
                rvalid <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (req_ready[0]) ready_cnt0++;
        if (req_ready[1]) ready_cnt1++;
    end

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input int idx, input logic [7:0] d, input string tag);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_valid[idx] = 1'b1;
        req_data[idx]  = d;
        for (int c = 0; c < 300 && !ok; c++) begin
            #1;
            if (req_ready[idx]) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) @(negedge clk);
        req_valid[idx] = 1'b0;
        check({tag, "_granted"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int na, nw, nr, ng;
    bit reached;

    initial begin
        req_valid = '0;
        req_data  = '0;
        err_clr   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_axi_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_INIT));

        // Release; first byte requested while INIT is still running
        rst_n = 1'b1;
        send_byte(0, 8'h41, "b41");
        wait_idle("b41");
        check("init_aw_addr", aw_log[0], CTRL_A);
        check("init_wdata", w_log[0], 32'h3);
        check("b41_aw_count", 32'(aw_log.size()), 32'd2);
        check("b41_ar_count", 32'(ar_log.size()), 32'd1);
        check("b41_ar_addr", ar_log[0], STAT_A);
        check("b41_aw_addr", aw_log[1], TX_A);
        check("b41_wdata", w_log[1], 32'h41);
        check("b41_ready_pulses", 32'(ready_cnt0), 32'd1);
        check("prot_strb", 32'({awprot, arprot, wstrb}), 32'h1);
        check("b41_err", 32'(err), 32'd0);

        // TX full on three polls, then room
        na = aw_log.size(); nr = ar_log.size();
        full_until = nr + 3;
        send_byte(1, 8'h55, "b55");
        wait_idle("b55");
        check("b55_reads", 32'(ar_log.size() - nr), 32'd4);
        check("b55_writes", 32'(aw_log.size() - na), 32'd1);
        check("b55_wdata", w_log[w_log.size()-1], 32'h55);
        check("b55_err", 32'(err), 32'd0);

        // Both requesters continuously valid for six bytes
        nw = w_log.size(); ng = ready_cnt0 + ready_cnt1; na = ready_cnt0;
        @(negedge clk);
        req_data[0] = 8'h10; req_data[1] = 8'h20; req_valid = 2'b11;
        reached = 1'b0;
        for (int c = 0; c < 2000 && !reached; c++) begin
            @(negedge clk);
            if (ready_cnt0 + ready_cnt1 - ng >= 6) reached = 1'b1;
        end
        req_valid = 2'b00;
        check("rr_six_grants", 32'(reached), 32'd1);
        wait_idle("rr");
        check("rr_write_count", 32'(w_log.size() - nw), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_order_%0d", i), w_log[nw+i], (i % 2 == 0) ? 32'h10 : 32'h20);
        end
        check("rr_req0_grants", 32'(ready_cnt0 - na), 32'd3);

        // STAT stuck full: timeout after MAX_POLL reads
        na = aw_log.size(); nr = ar_log.size();
        full_until = 32'h4000_0000;
        send_byte(0, 8'h77, "tmo");
        wait_idle("tmo");
        full_until = 0;
        check("tmo_reads", 32'(ar_log.size() - nr), 32'd4);
        check("tmo_writes", 32'(aw_log.size() - na), 32'd0);
        check("tmo_err_set", 32'(err), 32'd1);
        pulse_err_clr();
        check("tmo_err_cleared", 32'(err), 32'd0);
        na = aw_log.size();
        send_byte(1, 8'h99, "b99");
        wait_idle("b99");
        check("b99_writes", 32'(aw_log.size() - na), 32'd1);
        check("b99_wdata", w_log[w_log.size()-1], 32'h99);
        check("b99_err", 32'(err), 32'd0);

        // AW accepted three cycles ahead of W
        na = aw_log.size(); nw = w_log.size();
        cfg_w_delay = 3;
        send_byte(0, 8'h5A, "skew");
        wait_idle("skew");
        cfg_w_delay = 0;
        check("skew_aw_count", 32'(aw_log.size() - na), 32'd1);
        check("skew_w_count", 32'(w_log.size() - nw), 32'd1);
        check("skew_aw_addr", aw_log[aw_log.size()-1], TX_A);
        check("skew_wdata", w_log[w_log.size()-1], 32'h5A);
        check("skew_err", 32'(err), 32'd0);

        // SLVERR on the TX write
        na = aw_log.size();
        cfg_bresp = 2'b10;
        send_byte(1, 8'hC3, "slverr");
        wait_idle("slverr");
        cfg_bresp = 2'b00;
        check("slverr_writes", 32'(aw_log.size() - na), 32'd1);
        check("slverr_err", 32'(err), 32'd1);
        pulse_err_clr();
        check("slverr_cleared", 32'(err), 32'd0);

        // Reset while waiting on the STAT read data
        na = aw_log.size(); nw = w_log.size(); nr = ar_log.size();
        cfg_r_hold = 1'b1;
        send_byte(0, 8'h11, "rstr");
        reached = 1'b0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(negedge clk);
            if (dbg_state == ST_WAIT_R) reached = 1'b1;
        end
        check("rstr_in_wait_r", 32'(reached), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstr_valids_low", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        check("rstr_req_ready", 32'(req_ready), 32'd0);
        check("rstr_state", 32'(dbg_state), 32'(ST_INIT));
        repeat (2) @(negedge clk);
        cfg_r_hold = 1'b0;
        rst_n = 1'b1;
        wait_idle("rstr");
        check("rstr_reads", 32'(ar_log.size() - nr), 32'd1);
        check("rstr_writes", 32'(aw_log.size() - na), 32'd1);
        check("rstr_init_addr", aw_log[aw_log.size()-1], CTRL_A);
        check("rstr_init_wdata", w_log[w_log.size()-1], 32'h3);
        check("rstr_w_count", 32'(w_log.size() - nw), 32'd1);
        check("rstr_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
